// File: rtl/inst_fetcher_if.sv
// Fetch-side bus bundle: instruction-queue push port and memory-controller refill port.
// master = the fetcher, slave = the queue / memory controller side.
interface inst_fetcher_if;
  logic        IQ_is_full;
  logic        IQ_output_valid;
  logic [31:0] IQ_inst;
  logic [31:0] IQ_inst_pc;
  logic        IQ_predicted_to_jump;
  logic [31:0] IQ_predicted_pc;
  logic        MC_request;
  logic [31:0] MC_addr;
  logic        MC_valid;
  logic [31:0] MC_inst;

  modport master (
    input  IQ_is_full, MC_valid, MC_inst,
    output IQ_output_valid, IQ_inst, IQ_inst_pc, IQ_predicted_to_jump, IQ_predicted_pc,
           MC_request, MC_addr
  );

  modport slave (
    output IQ_is_full, MC_valid, MC_inst,
    input  IQ_output_valid, IQ_inst, IQ_inst_pc, IQ_predicted_to_jump, IQ_predicted_pc,
           MC_request, MC_addr
  );
endinterface

// File: rtl/inst_fetcher.sv
// Fetch stage: PC, direct-mapped one-word-line icache with MC refill, static/BHT prediction.
// Define IF_BHT_EN to predict conditional branches with a 2-bit saturating counter table.
module inst_fetcher #(
  parameter int unsigned ICACHE_INDEX_W = 6,
  parameter int unsigned BHT_INDEX_W    = 8,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  inst_fetcher_if.master        bus,
  input  logic                  ROB_roll_back_flag,
  input  logic [31:0]           ROB_roll_back_pc,
  input  logic                  ROB_br_update_valid,
  input  logic [31:0]           ROB_br_pc,
  input  logic                  ROB_br_taken
);
  localparam int unsigned LINES = 1 << ICACHE_INDEX_W;
  localparam int unsigned TAG_W = 30 - ICACHE_INDEX_W;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                    state_q;
  logic [31:0]               pc_q;
  logic [LINES-1:0]          line_vld_q;
  logic [TAG_W-1:0]          line_tag_q  [LINES];
  logic [31:0]               line_data_q [LINES];

  logic [ICACHE_INDEX_W-1:0] fetch_idx, fill_idx;
  logic [TAG_W-1:0]          fetch_tag, fill_tag;
  logic                      hit;
  logic [31:0]               hit_inst;
  logic signed [31:0]        jal_off, br_off;
  logic                      br_taken;
  logic                      pred_taken_d;
  logic [31:0]               pred_pc_d;
  logic                      unused_mc;

  assign fetch_idx = pc_q[ICACHE_INDEX_W+1:2];
  assign fetch_tag = pc_q[31:ICACHE_INDEX_W+2];
  assign fill_idx  = bus.MC_addr[ICACHE_INDEX_W+1:2];
  assign fill_tag  = bus.MC_addr[31:ICACHE_INDEX_W+2];
  assign unused_mc = ^bus.MC_addr[1:0];
  assign hit_inst  = line_data_q[fetch_idx];
  assign hit       = line_vld_q[fetch_idx] && (line_tag_q[fetch_idx] == fetch_tag);

  assign jal_off = {{11{hit_inst[31]}}, hit_inst[31], hit_inst[19:12], hit_inst[20],
                    hit_inst[30:21], 1'b0};
  assign br_off  = {{19{hit_inst[31]}}, hit_inst[31], hit_inst[7], hit_inst[30:25],
                    hit_inst[11:8], 1'b0};

`ifdef IF_BHT_EN
  localparam int unsigned BHT_N = 1 << BHT_INDEX_W;

  logic [1:0]             bht_q [BHT_N];
  logic [BHT_INDEX_W-1:0] bht_rd_idx, bht_wr_idx;
  logic                   unused_bht;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  assign bht_rd_idx = pc_q[BHT_INDEX_W+1:2];
  assign bht_wr_idx = ROB_br_pc[BHT_INDEX_W+1:2];
  assign unused_bht = ^{ROB_br_pc[31:BHT_INDEX_W+2], ROB_br_pc[1:0]};
  // Prediction reads the pre-update counter when training hits the same entry.
  assign br_taken   = bht_q[bht_rd_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (rdy && ROB_br_update_valid) begin
      bht_q[bht_wr_idx] <= sat_step(bht_q[bht_wr_idx], ROB_br_taken);
    end
  end
`else
  logic unused_bht;
  assign unused_bht = ^{ROB_br_update_valid, ROB_br_pc, ROB_br_taken, BHT_INDEX_W[0]};
  // Static rule: backward conditional branches (negative offset) are taken.
  assign br_taken   = hit_inst[31];
`endif

  always_comb begin
    pred_taken_d = 1'b0;
    pred_pc_d    = pc_q + 32'd4;
    case (hit_inst[6:0])
      7'b1101111: begin
        pred_taken_d = 1'b1;
        pred_pc_d    = pc_q + $unsigned(jal_off);
      end
      7'b1100011: begin
        if (br_taken) begin
          pred_taken_d = 1'b1;
          pred_pc_d    = pc_q + $unsigned(br_off);
        end
      end
      default: ;
    endcase
  end

  // Line payload carries no reset; the valid bits below gate every use.
  always_ff @(posedge clk) begin
    if (rdy && (state_q == WAIT_MEM) && bus.MC_valid) begin
      line_tag_q[fill_idx]  <= fill_tag;
      line_data_q[fill_idx] <= bus.MC_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                  <= IDLE;
      pc_q                     <= RESET_PC;
      line_vld_q               <= '0;
      bus.IQ_output_valid      <= 1'b0;
      bus.IQ_inst              <= 32'h0;
      bus.IQ_inst_pc           <= 32'h0;
      bus.IQ_predicted_to_jump <= 1'b0;
      bus.IQ_predicted_pc      <= 32'h0;
      bus.MC_request           <= 1'b0;
      bus.MC_addr              <= 32'h0;
    end else if (!rdy) begin
      bus.IQ_output_valid <= 1'b0;
    end else begin
      bus.IQ_output_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ROB_roll_back_flag) begin
            pc_q <= ROB_roll_back_pc;
          end else if (!bus.IQ_is_full && hit) begin
            bus.IQ_output_valid      <= 1'b1;
            bus.IQ_inst              <= hit_inst;
            bus.IQ_inst_pc           <= pc_q;
            bus.IQ_predicted_to_jump <= pred_taken_d;
            bus.IQ_predicted_pc      <= pred_pc_d;
            pc_q                     <= pred_pc_d;
          end else if (!bus.IQ_is_full) begin
            bus.MC_request <= 1'b1;
            bus.MC_addr    <= pc_q;
            state_q        <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          // The outstanding refill always completes, even across a redirect.
          if (ROB_roll_back_flag) pc_q <= ROB_roll_back_pc;
          if (bus.MC_valid) begin
            line_vld_q[fill_idx] <= 1'b1;
            bus.MC_request       <= 1'b0;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized scoreboard bench for inst_fetcher: a program image defined by address hashing,
// a memory-controller responder, and a monitor that replays the predicted fetch stream.
`timescale 1ns/1ps
module tb_inst_fetcher;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          NCYC     = 3000;
  localparam logic [1:0]  K_JAL = 2'd0, K_BR = 2'd1, K_OTH = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  kind;
    logic [31:0] off;
  } word_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
  } train_t;

  logic        clk = 1'b0;
  logic        rst, rdy, rb_flag, br_upd, br_tk;
  logic [31:0] rb_pc, br_pc;

  inst_fetcher_if bus ();

  inst_fetcher #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus),
    .ROB_roll_back_flag(rb_flag), .ROB_roll_back_pc(rb_pc),
    .ROB_br_update_valid(br_upd), .ROB_br_pc(br_pc), .ROB_br_taken(br_tk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pushes = 0;
  int fire_cyc = -1;
  logic edge_full = 1'b0, edge_rdy = 1'b0;

  logic [31:0] redirect_q [$];
  train_t      train_q    [$];
  logic [1:0]  bht_m      [256];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    edge_full <= bus.IQ_is_full;
    edge_rdy  <= rdy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program image: every word address maps to a fixed instruction with a known offset.
  function automatic word_t mem_word(input logic [31:0] a);
    logic [31:0] h, s;
    word_t w;
    h = (a >> 2) * 32'h9E3779B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    s = {28'b0, h[9:6]};
    w.kind = K_OTH;
    w.off  = 32'h0;
    if (a[31:2] == 30'h0) begin
      w.inst = 32'h00000013;
      return w;
    end
    if (a[31:2] == 30'h4) begin
      w.inst = 32'hFE000EE3;
      w.kind = K_BR;
      w.off  = 32'hFFFF_FFFC;
      return w;
    end
    case (h[3:0])
      4'd0, 4'd1: begin
        w.kind = K_JAL;
        w.off  = (h[5:4] == 2'd3) ? {{11{h[31]}}, h[31:13], 2'b00} : ((s - 32'd8) << 2);
        w.inst = {w.off[20], w.off[10:1], w.off[11], w.off[19:12], h[20:16], 7'b1101111};
      end
      4'd2, 4'd3, 4'd4, 4'd5: begin
        w.kind = K_BR;
        w.off  = (h[5:4] == 2'd3) ? {{19{h[31]}}, h[31:21], 2'b00} : ((s - 32'd8) << 2);
        w.inst = {w.off[12], w.off[10:5], h[24:20], h[19:15], h[14:12], w.off[4:1],
                  w.off[11], 7'b1100011};
      end
      4'd6:    w.inst = {h[31:20], h[19:15], 3'b000, h[11:7], 7'b1100111};
      default: w.inst = {h[31:20], h[19:15], 3'b000, h[11:7], 7'b0010011};
    endcase
    return w;
  endfunction

  task automatic predict(input logic [31:0] pc, output logic [31:0] inst,
                         output logic tk, output logic [31:0] npc);
    word_t w;
    w    = mem_word(pc);
    inst = w.inst;
    tk   = 1'b0;
    npc  = pc + 32'd4;
    if (w.kind == K_JAL) begin
      tk  = 1'b1;
      npc = pc + w.off;
    end else if (w.kind == K_BR) begin
`ifdef IF_BHT_EN
      tk = bht_m[(pc >> 2) % 256][1];
`else
      tk = w.off[31];
`endif
      if (tk) npc = pc + w.off;
    end
  endtask

  // Monitor: checks every push against the reference stream.
  initial begin
    logic [31:0] exp_pc, e_inst, e_npc;
    logic        e_tk;
    train_t      t;
    int          idx;
    exp_pc = RESET_PC;
    for (int i = 0; i < 256; i++) bht_m[i] = 2'b01;
    @(negedge rst);
    forever begin
      @(negedge clk);
      while (redirect_q.size() > 0) exp_pc = redirect_q.pop_front();
      if (bus.IQ_output_valid === 1'b1) begin
        predict(exp_pc, e_inst, e_tk, e_npc);
        chk("push_pc",    bus.IQ_inst_pc, exp_pc);
        chk("push_inst",  bus.IQ_inst, e_inst);
        chk("push_taken", 32'(bus.IQ_predicted_to_jump), 32'(e_tk));
        chk("push_npc",   bus.IQ_predicted_pc, e_npc);
        chk("push_flow",  {30'b0, edge_full, edge_rdy}, 32'h1);
        pushes++;
        if (pushes == 1) chk("first_push_latency", 32'(cyc - fire_cyc), 32'd2);
        exp_pc = e_npc;
      end
      while (train_q.size() > 0) begin
        t   = train_q.pop_front();
        idx = int'((t.pc >> 2) % 256);
        if (t.tk && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'b01;
        else if (!t.tk && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'b01;
      end
    end
  end

  // Stimulus and memory-controller responder.
  initial begin
    logic        busy, seen_req, rb_pend, tr_pend, rdy_n, full_n;
    logic [31:0] req_addr, rb_tgt;
    train_t      tr;
    int          lat;
    busy = 0; seen_req = 0; rb_pend = 0; tr_pend = 0; lat = 0;
    req_addr = 0; rb_tgt = 0; tr = '0;
    rst = 1'b1; rdy = 1'b0; rb_flag = 1'b0; rb_pc = 0;
    br_upd = 1'b0; br_pc = 0; br_tk = 1'b0;
    bus.IQ_is_full = 1'b0; bus.MC_valid = 1'b0; bus.MC_inst = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",   32'(bus.IQ_output_valid), 32'h0);
    chk("rst_mc_req",  32'(bus.MC_request), 32'h0);
    chk("rst_mc_addr", bus.MC_addr, 32'h0);
    chk("rst_inst",    bus.IQ_inst, 32'h0);
    chk("rst_inst_pc", bus.IQ_inst_pc, 32'h0);
    chk("rst_jump",    32'(bus.IQ_predicted_to_jump), 32'h0);
    chk("rst_ppc",     bus.IQ_predicted_pc, 32'h0);
    rst = 1'b0;
    rdy = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (rb_pend) begin redirect_q.push_back(rb_tgt); rb_pend = 0; end
      if (tr_pend) begin train_q.push_back(tr); tr_pend = 0; end

      if (bus.MC_request === 1'b1) begin
        if (!busy) begin
          busy     = 1;
          lat      = $urandom_range(1, 4);
          req_addr = bus.MC_addr;
          if (!seen_req) begin
            chk("first_req_addr", bus.MC_addr, RESET_PC);
            seen_req = 1;
          end
        end else begin
          chk("mc_addr_stable", bus.MC_addr, req_addr);
        end
      end else begin
        busy = 0;
      end

      rdy_n  = 1'b1;
      full_n = 1'b0;
      if (c >= 40) begin
        rdy_n  = ($urandom_range(0, 99) >= 12);
        full_n = ($urandom_range(0, 99) < 25);
        if (c >= 200 && c < 205) full_n = 1'b1;
        if (c >= 300 && c < 303) rdy_n  = 1'b0;
      end
      rdy            = rdy_n;
      bus.IQ_is_full = full_n;

      bus.MC_valid = 1'b0;
      bus.MC_inst  = $urandom;
      if (busy) begin
        if (lat == 0) begin
          if (rdy_n) begin
            bus.MC_valid = 1'b1;
            bus.MC_inst  = mem_word(req_addr).inst;
            if (fire_cyc < 0) fire_cyc = cyc;
            lat = 3;
          end
        end else begin
          lat--;
        end
      end

      rb_flag = 1'b0;
      if (c >= 40 && rdy_n && $urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 9))
          0:       rb_tgt = 32'hFFFF_FFF0;
          1:       rb_tgt = $urandom & 32'hFFFF_FFFC;
          2:       rb_tgt = 32'h0000_0080;
          default: rb_tgt = 32'($urandom_range(0, 127)) << 2;
        endcase
        rb_flag = 1'b1;
        rb_pc   = rb_tgt;
        rb_pend = 1;
      end

      br_upd = 1'b0;
`ifdef IF_BHT_EN
      if (c >= 40 && rdy_n && $urandom_range(0, 99) < 15) begin
        tr.pc  = ($urandom_range(0, 3) == 0) ? 32'h40 : (32'($urandom_range(0, 255)) << 2);
        tr.tk  = ($urandom_range(0, 2) == 0);
        br_upd = 1'b1;
        br_pc  = tr.pc;
        br_tk  = tr.tk;
        tr_pend = 1;
      end
`endif
    end

    @(posedge clk);
    #1;
    rdy = 1'b1; rb_flag = 1'b0; br_upd = 1'b0; bus.MC_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("progress", 32'(pushes > 100), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end fetch stage directly upstream of the instruction queue.
- Holds the PC and a direct-mapped instruction cache; refills misses from the memory controller.
- Statically predicts control flow and pushes one {inst, pc, predicted_to_jump, predicted_pc} per cycle into the queue when the queue is not full.
- Redirects its PC on a ROB rollback.

Parameters:
ICACHE_INDEX_W, 6, log2 of icache entries (64 one-word lines)
BHT_INDEX_W, 8, log2 of BHT entries (used only with IF_BHT_EN)
RESET_PC, 32'h0, PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low = stall
IQ_is_full  in  1  queue cannot accept this cycle (combinational from queue)
IQ_output_valid  out  1  one-cycle push strobe to queue
IQ_inst  out  32  fetched instruction
IQ_inst_pc  out  32  its PC
IQ_predicted_to_jump  out  1  predicted taken
IQ_predicted_pc  out  32  predicted next PC
MC_request  out  1  instruction-fetch request to memory controller
MC_addr  out  32  word address of request
MC_valid  in  1  one-cycle pulse: MC_inst valid for MC_addr
MC_inst  in  32  returned instruction word
ROB_roll_back_flag  in  1  high = flush front end, redirect
ROB_roll_back_pc  in  32  redirect target
ROB_br_update_valid  in  1  branch resolved (BHT training)
ROB_br_pc  in  32  resolved branch PC
ROB_br_taken  in  1  resolved outcome

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; state=IDLE; all icache valid bits=0; IQ_output_valid=0; MC_request=0; MC_addr=0; IQ_inst, IQ_inst_pc, IQ_predicted_pc=0; IQ_predicted_to_jump=0. BHT counters=2'b01.
- rdy=0: IQ_output_valid<=0; all other state holds; no fetch lost (pc not advanced).
- All outputs registered; IQ_output_valid is high for exactly the cycle after a push decision, never two cycles for one fetch.
- Icache geometry: index=pc[ICACHE_INDEX_W+1:2]; tag=pc[31:ICACHE_INDEX_W+2]; hit = valid & tag match.
- FSM states: IDLE, WAIT_MEM.
- IDLE, priority order:
  - rollback: pc<=ROB_roll_back_pc; IQ_output_valid<=0.
  - else IQ_is_full=0 and hit: push next cycle; pc<=predicted next PC.
  - else IQ_is_full=0 and miss: MC_request<=1; MC_addr<=pc; ->WAIT_MEM; IQ_output_valid<=0.
  - else (IQ full): IQ_output_valid<=0; hold.
- WAIT_MEM:
  - MC_request/MC_addr held stable until MC_valid.
  - On MC_valid: line[MC_addr index] <= {valid, tag, MC_inst}; MC_request<=0; ->IDLE. The hit on the refilled line occurs on the next IDLE cycle; no bypass, so miss latency = MC latency + 2.
  - Rollback in WAIT_MEM: pc<=ROB_roll_back_pc at once. Outstanding request is not aborted; its data is still written to the cache, then ->IDLE.
  - Rollback in the same cycle as MC_valid: cache written, pc=rollback pc, ->IDLE.
- Prediction (combinational on the hit word):
  - opcode 1101111 (JAL): taken; target=pc+sext(J-imm).
  - opcode 1100011 (branch): static taken iff imm[12]=1 (backward); target=pc+sext(B-imm); else pc+4.
  - JALR and all others: not taken; pc+4.
  - predicted_pc = next pc.
- All PC arithmetic is 32-bit, wraps mod 2^32; bits [1:0] are never used for indexing.
- A push decided in the cycle a rollback arrives is suppressed; rollback always wins over a hit.

Optional Feature:
- Macro IF_BHT_EN.
- Defined: branches are predicted by a 2-bit saturating counter table indexed by pc[BHT_INDEX_W+1:2]; taken iff counter[1]=1.
  - On ROB_br_update_valid, counter[ROB_br_pc index] increments if ROB_br_taken, else decrements, saturating at 0 and 3.
  - Training and prediction in the same cycle: prediction uses the old value.
- Undefined: static backward-taken rule; BHT ports ignored; no table storage.

Test Plan:
- Reset, MC returns 32'h00000013 at addr 0 after 3 cycles -> MC_request=1 with MC_addr=0 held until MC_valid; one push: inst=0x13, pc=0, predicted_to_jump=0, predicted_pc=4.
- Cached loop, inst at 0x10 = 0xFE000EE3 (beq x0,x0,-4) -> push pc=0x10, predicted_to_jump=1, predicted_pc=0x0C; next fetch at 0x0C.
- IQ_is_full=1 for 5 cycles with hits pending -> IQ_output_valid=0 throughout; pc unchanged; resumes in order with no duplicate or skipped PC.
- Rollback to 0x80 while in WAIT_MEM for 0x20 -> request for 0x20 stays asserted until MC_valid; line 0x20 filled; next request is 0x80; no push of 0x20.
- rdy=0 for 3 cycles mid-stream -> no pushes, state frozen; after rdy=1 the next push is the PC that was pending.
- IF_BHT_EN: three not-taken updates on a backward branch at 0x40 -> subsequent fetch of 0x40 predicts not-taken, predicted_pc=0x44.
